act_stream_unit: RTL and testbench

- Streaming, parametrised activation stage for the CNN datapath, placed between the convolution/accumulator output and the pooling/storage stage.
- Accepts one row of LANES signed fixed-point values per beat over a valid/ready handshake.
- Applies a runtime-selected activation: bypass, ReLU, leaky ReLU or clipped ReLU.
- Emits results after a fixed 2-cycle pipeline with full backpressure, plus a per-frame count of zero outputs for sparsity statistics.

---
 rtl/cnn_pkg.sv | 15 +
 rtl/act_lane.sv | 58 +++++
 rtl/act_stream_unit.sv | 204 ++++++++++++++++++++
 tb/tb_act_stream_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath: activation mode encodings and the
// default lane geometry used by the conv, activation and pool blocks.
package cnn_pkg;

    localparam int CNN_DATA_W = 16;
    localparam int CNN_LANES  = 6;

    typedef enum logic [1:0] {
        ACT_BYPASS = 2'b00,
        ACT_RELU   = 2'b01,
        ACT_LEAKY  = 2'b10,
        ACT_CLIP   = 2'b11
    } act_mode_e;

endpackage

// File: rtl/act_lane.sv
// Single-lane combinational activation: bypass, ReLU, leaky ReLU or clipped ReLU
// on one signed two's-complement value.
module act_lane
    import cnn_pkg::*;
#(
    parameter int DATA_W     = CNN_DATA_W,
    parameter int LEAK_SHIFT = 3
) (
    input  logic [DATA_W-1:0] x,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] clip,
    output logic [DATA_W-1:0] y
);

    logic x_neg_s;
    logic clip_nonpos_s;

    assign x_neg_s       = x[DATA_W-1];
    assign clip_nonpos_s = clip[DATA_W-1] || (clip == {DATA_W{1'b0}});

    // Per-mode lane transfer function
    always_comb begin
        y = x;
        case (act_mode_e'(mode))
            ACT_BYPASS: begin
                y = x;
            end
            ACT_RELU: begin
                if (x_neg_s) begin
                    y = {DATA_W{1'b0}};
                end else begin
                    y = x;
                end
            end
            ACT_LEAKY: begin
                // Arithmetic shift floors toward minus infinity, so -1 stays -1
                if (x_neg_s) begin
                    y = $signed(x) >>> LEAK_SHIFT;
                end else begin
                    y = x;
                end
            end
            ACT_CLIP: begin
                if (x_neg_s || clip_nonpos_s) begin
                    y = {DATA_W{1'b0}};
                end else if ($signed(x) > $signed(clip)) begin
                    y = clip;
                end else begin
                    y = x;
                end
            end
            default: begin
                y = x;
            end
        endcase
    end

endmodule

// File: rtl/act_stream_unit.sv
// Two-stage streaming activation unit with valid/ready backpressure, per-frame
// configuration latching and a saturating per-frame zero-lane counter.
module act_stream_unit
    import cnn_pkg::*;
#(
    parameter int DATA_W     = CNN_DATA_W,
    parameter int LANES      = CNN_LANES,
    parameter int LEAK_SHIFT = 3,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              cfg_mode,
    input  logic [DATA_W-1:0]       cfg_clip,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic                    out_last,
    output logic [CNT_W-1:0]        frame_zero_cnt,
    output logic                    frame_done
);

    localparam int ZC_W = $clog2(LANES + 1);

    logic                    s1_valid_q, s1_valid_d;
    logic [LANES*DATA_W-1:0] s1_data_q, s1_data_d;
    logic                    s1_last_q, s1_last_d;
    logic                    s2_valid_q, s2_valid_d;
    logic [LANES*DATA_W-1:0] s2_data_q, s2_data_d;
    logic                    s2_last_q, s2_last_d;
    logic [ZC_W-1:0]         s2_zeros_q, s2_zeros_d;
    logic [1:0]              mode_q, mode_d;
    logic [DATA_W-1:0]       clip_q, clip_d;
    logic                    frame_start_q, frame_start_d;
    logic [CNT_W-1:0]        run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0]        frame_zero_cnt_q, frame_zero_cnt_d;
    logic                    frame_done_q, frame_done_d;

    logic                    s2_adv_s;
    logic                    in_ready_s;
    logic                    in_fire_s;
    logic                    out_fire_s;
    logic [1:0]              eff_mode_s;
    logic [DATA_W-1:0]       eff_clip_s;
    logic [LANES*DATA_W-1:0] act_data_s;
    logic [ZC_W-1:0]         s1_zeros_s;
    logic [CNT_W:0]          cnt_sum_s;
    logic [CNT_W-1:0]        cnt_sat_s;

    assign s2_adv_s   = !s2_valid_q || out_ready;
    assign in_ready_s = !s1_valid_q || s2_adv_s;
    assign in_fire_s  = in_valid && in_ready_s;
    assign out_fire_s = s2_valid_q && out_ready;

    // The first beat of a frame is computed with the live config it also latches
    assign eff_mode_s = frame_start_q ? cfg_mode : mode_q;
    assign eff_clip_s = frame_start_q ? cfg_clip : clip_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        act_lane #(
            .DATA_W     (DATA_W),
            .LEAK_SHIFT (LEAK_SHIFT)
        ) u_act_lane (
            .x    (in_data[i*DATA_W +: DATA_W]),
            .mode (eff_mode_s),
            .clip (eff_clip_s),
            .y    (act_data_s[i*DATA_W +: DATA_W])
        );
    end

    // Zero lanes of the beat waiting in S1, carried into S2 alongside its data
    always_comb begin
        s1_zeros_s = {ZC_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            if (s1_data_q[i*DATA_W +: DATA_W] == {DATA_W{1'b0}}) begin
                s1_zeros_s = s1_zeros_s + ZC_W'(1);
            end else begin
                s1_zeros_s = s1_zeros_s;
            end
        end
    end

    // Pipeline stage advance: each stage loads when its successor can take its beat
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_last_d  = s1_last_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_last_d  = s2_last_q;
        s2_zeros_d = s2_zeros_q;
        if (in_ready_s) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = act_data_s;
                s1_last_d = in_last;
            end else begin
                s1_data_d = s1_data_q;
                s1_last_d = s1_last_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (s2_adv_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d  = s1_data_q;
                s2_last_d  = s1_last_q;
                s2_zeros_d = s1_zeros_s;
            end else begin
                s2_data_d  = s2_data_q;
                s2_last_d  = s2_last_q;
                s2_zeros_d = s2_zeros_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Config latch: sampled only on the first accepted beat of each frame
    always_comb begin
        mode_d        = mode_q;
        clip_d        = clip_q;
        frame_start_d = frame_start_q;
        if (in_fire_s) begin
            frame_start_d = in_last;
            if (frame_start_q) begin
                mode_d = cfg_mode;
                clip_d = cfg_clip;
            end else begin
                mode_d = mode_q;
                clip_d = clip_q;
            end
        end else begin
            frame_start_d = frame_start_q;
        end
    end

    assign cnt_sum_s = {1'b0, run_cnt_q} + {{(CNT_W + 1 - ZC_W){1'b0}}, s2_zeros_q};
    assign cnt_sat_s = cnt_sum_s[CNT_W] ? {CNT_W{1'b1}} : cnt_sum_s[CNT_W-1:0];

    // Zero counter accumulates on output transfer, so stalled beats count once
    always_comb begin
        run_cnt_d        = run_cnt_q;
        frame_zero_cnt_d = frame_zero_cnt_q;
        frame_done_d     = 1'b0;
        if (out_fire_s) begin
            if (s2_last_q) begin
                frame_zero_cnt_d = cnt_sat_s;
                frame_done_d     = 1'b1;
                run_cnt_d        = {CNT_W{1'b0}};
            end else begin
                run_cnt_d        = cnt_sat_s;
            end
        end else begin
            run_cnt_d = run_cnt_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q       <= 1'b0;
            s1_data_q        <= {(LANES*DATA_W){1'b0}};
            s1_last_q        <= 1'b0;
            s2_valid_q       <= 1'b0;
            s2_data_q        <= {(LANES*DATA_W){1'b0}};
            s2_last_q        <= 1'b0;
            s2_zeros_q       <= {ZC_W{1'b0}};
            mode_q           <= ACT_RELU;
            clip_q           <= {DATA_W{1'b0}};
            frame_start_q    <= 1'b1;
            run_cnt_q        <= {CNT_W{1'b0}};
            frame_zero_cnt_q <= {CNT_W{1'b0}};
            frame_done_q     <= 1'b0;
        end else begin
            s1_valid_q       <= s1_valid_d;
            s1_data_q        <= s1_data_d;
            s1_last_q        <= s1_last_d;
            s2_valid_q       <= s2_valid_d;
            s2_data_q        <= s2_data_d;
            s2_last_q        <= s2_last_d;
            s2_zeros_q       <= s2_zeros_d;
            mode_q           <= mode_d;
            clip_q           <= clip_d;
            frame_start_q    <= frame_start_d;
            run_cnt_q        <= run_cnt_d;
            frame_zero_cnt_q <= frame_zero_cnt_d;
            frame_done_q     <= frame_done_d;
        end
    end

    assign in_ready       = in_ready_s;
    assign out_valid      = s2_valid_q;
    assign out_data       = s2_data_q;
    assign out_last       = s2_last_q;
    assign frame_zero_cnt = frame_zero_cnt_q;
    assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_act_stream_unit.sv
// Directed self-checking bench for act_stream_unit: one task per scenario,
// inputs driven and outputs sampled on the falling clock edge.
module tb_act_stream_unit;

    localparam int DW = 16;
    localparam int LN = 6;
    localparam int CW = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       cfg_mode;
    logic [DW-1:0]    cfg_clip;
    logic             in_valid;
    logic             in_ready;
    logic [LN*DW-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [LN*DW-1:0] out_data;
    logic             out_last;
    logic [CW-1:0]    frame_zero_cnt;
    logic             frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    act_stream_unit #(.DATA_W(DW), .LANES(LN), .LEAK_SHIFT(3), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_mode       (cfg_mode),
        .cfg_clip       (cfg_clip),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_last        (in_last),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .frame_zero_cnt (frame_zero_cnt),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [LN*DW-1:0] pk(input int a, input int b, input int c,
                                            input int d, input int e, input int f);
        pk = {f[15:0], e[15:0], d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    function automatic int relu(input int v);
        relu = (v < 0) ? 0 : v;
    endfunction

    // Drive one last-beat frame at a falling edge; returns at the falling edge after acceptance
    task automatic send_single(input logic [LN*DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_mode = 2'b01; cfg_clip = 16'd0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 96'd0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        n_cmp++; if (frame_zero_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_zero_cnt: got %0d want 0", frame_zero_cnt); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_relu();
        logic [LN*DW-1:0] exp_d;
        cfg_mode = 2'b01; out_ready = 1'b1;
        exp_d = pk(0, 0, 7, 0, 32767, 1);
        send_single(pk(-5, 0, 7, -32768, 32767, 1));
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL relu_latency_early: got %b want 0", out_valid); end
        @(posedge clk); @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_d || out_last !== 1'b1) begin
            n_bad++; $display("FAIL relu_out: got v=%b d=%h l=%b want v=1 d=%h l=1", out_valid, out_data, out_last, exp_d);
        end
        @(posedge clk); @(negedge clk);
        n_cmp++; if (frame_done !== 1'b1 || frame_zero_cnt !== 16'd3) begin
            n_bad++; $display("FAIL relu_count: got done=%b cnt=%0d want done=1 cnt=3", frame_done, frame_zero_cnt);
        end
        @(posedge clk); @(negedge clk);
        n_cmp++; if (frame_done !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL relu_pulse_width: got done=%b v=%b want 0 0", frame_done, out_valid);
        end
    endtask

    task automatic test_leaky();
        logic [LN*DW-1:0] exp_d;
        cfg_mode = 2'b10; out_ready = 1'b1;
        exp_d = pk(-1, -1, -3, 16, 0, -4096);
        send_single(pk(-8, -1, -17, 16, 0, -32768));
        @(posedge clk); @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_d) begin
            n_bad++; $display("FAIL leaky_out: got v=%b d=%h want v=1 d=%h", out_valid, out_data, exp_d);
        end
        @(posedge clk); @(negedge clk);
        n_cmp++; if (frame_done !== 1'b1 || frame_zero_cnt !== 16'd1) begin
            n_bad++; $display("FAIL leaky_count: got done=%b cnt=%0d want done=1 cnt=1", frame_done, frame_zero_cnt);
        end
    endtask

    task automatic test_clip();
        logic [LN*DW-1:0] exp_d;
        cfg_mode = 2'b11; cfg_clip = 16'd100; out_ready = 1'b1;
        exp_d = pk(100, 100, 99, 0, 0, 100);
        send_single(pk(150, 100, 99, -3, 0, 32767));
        @(posedge clk); @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_d) begin
            n_bad++; $display("FAIL clip_out: got v=%b d=%h want v=1 d=%h", out_valid, out_data, exp_d);
        end
        @(posedge clk); @(negedge clk);
        n_cmp++; if (frame_done !== 1'b1 || frame_zero_cnt !== 16'd2) begin
            n_bad++; $display("FAIL clip_count: got done=%b cnt=%0d want done=1 cnt=2", frame_done, frame_zero_cnt);
        end
        cfg_clip = 16'hFFFB;
        send_single(pk(150, 100, 99, -3, 0, 32767));
        @(posedge clk); @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 96'd0) begin
            n_bad++; $display("FAIL clip_neg_out: got v=%b d=%h want v=1 d=0", out_valid, out_data);
        end
        @(posedge clk); @(negedge clk);
        n_cmp++; if (frame_done !== 1'b1 || frame_zero_cnt !== 16'd6) begin
            n_bad++; $display("FAIL clip_neg_count: got done=%b cnt=%0d want done=1 cnt=6", frame_done, frame_zero_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [LN*DW-1:0] bp_in [10];
        logic [LN*DW-1:0] bp_exp [10];
        logic [15:0]      pat;
        logic [LN*DW-1:0] held;
        logic             stalled;
        logic             acc;
        logic             xfer;
        int               sent;
        int               got;
        int               inflight;
        int               exp_z;
        int               v;
        int               r;
        exp_z = 0;
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < LN; j++) begin
                v = k * 7 + j * 13 - 40;
                r = relu(v);
                bp_in[k][j*DW +: DW]  = v[15:0];
                bp_exp[k][j*DW +: DW] = r[15:0];
                if (r == 0) exp_z++;
            end
        end
        pat = 16'b1011_0010_0110_1001;
        cfg_mode = 2'b01; sent = 0; got = 0; inflight = 0; stalled = 1'b0; held = '0;
        for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
            if (stalled) begin
                n_cmp++; if (out_valid !== 1'b1 || out_data !== held) begin
                    n_bad++; $display("FAIL bp_stall_hold: got v=%b d=%h want v=1 d=%h", out_valid, out_data, held);
                end
            end
            out_ready = pat[cyc % 16];
            if (sent < 10) begin
                in_valid = 1'b1; in_data = bp_in[sent]; in_last = (sent == 9);
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
            #1;
            if (inflight == 2) begin
                n_cmp++; if (in_ready !== out_ready) begin
                    n_bad++; $display("FAIL bp_full_in_ready: got %b want %b", in_ready, out_ready);
                end
            end
            acc  = in_valid && in_ready;
            xfer = out_valid && out_ready;
            if (xfer) begin
                n_cmp++; if (out_data !== bp_exp[got] || out_last !== (got == 9)) begin
                    n_bad++; $display("FAIL bp_beat%0d: got d=%h l=%b want d=%h l=%b", got, out_data, out_last, bp_exp[got], (got == 9));
                end
                got++;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            if (acc) sent++;
            inflight = inflight + (acc ? 1 : 0) - (xfer ? 1 : 0);
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        n_cmp++; if (got !== 10) begin n_bad++; $display("FAIL bp_beat_count: got %0d want 10", got); end
        n_cmp++; if (frame_done !== 1'b1 || frame_zero_cnt !== exp_z[15:0] || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL bp_count: got done=%b cnt=%0d v=%b want done=1 cnt=%0d v=0", frame_done, frame_zero_cnt, out_valid, exp_z);
        end
        @(negedge clk);
    endtask

    task automatic test_midframe_cfg();
        logic [LN*DW-1:0] beats [3];
        logic [LN*DW-1:0] exps [3];
        beats[0] = pk(-1, 2, -3, 4, -5, 6);
        beats[1] = pk(-100, 100, 0, -200, 200, -300);
        beats[2] = pk(9, -9, 8, -8, 7, -7);
        exps[0]  = pk(0, 2, 0, 4, 0, 6);
        exps[1]  = pk(0, 100, 0, 0, 200, 0);
        exps[2]  = pk(9, 0, 8, 0, 7, 0);
        cfg_mode = 2'b01; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c >= 2) begin
                n_cmp++; if (out_valid !== 1'b1 || out_data !== exps[c-2] || out_last !== (c == 4)) begin
                    n_bad++; $display("FAIL mid_beat%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", c - 2, out_valid, out_data, out_last, exps[c-2], (c == 4));
                end
            end
            if (c == 1) cfg_mode = 2'b00;
            if (c < 3) begin
                in_valid = 1'b1; in_data = beats[c]; in_last = (c == 2);
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
            @(posedge clk); @(negedge clk);
        end
        n_cmp++; if (frame_done !== 1'b1 || frame_zero_cnt !== 16'd10) begin
            n_bad++; $display("FAIL mid_count: got done=%b cnt=%0d want done=1 cnt=10", frame_done, frame_zero_cnt);
        end
        send_single(pk(-7, -8, 9, 0, -32768, 5));
        @(posedge clk); @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== pk(-7, -8, 9, 0, -32768, 5)) begin
            n_bad++; $display("FAIL mid_next_bypass: got v=%b d=%h want v=1 d=%h", out_valid, out_data, pk(-7, -8, 9, 0, -32768, 5));
        end
        @(posedge clk); @(negedge clk);
        n_cmp++; if (frame_zero_cnt !== 16'd1) begin n_bad++; $display("FAIL mid_next_count: got %0d want 1", frame_zero_cnt); end
    endtask

    task automatic test_reset_midframe();
        logic spurious;
        cfg_mode = 2'b01; out_ready = 1'b0;
        in_valid = 1'b1; in_data = pk(0, 0, 0, 0, 0, 0); in_last = 1'b0;
        @(posedge clk); @(negedge clk);
        in_data = pk(-1, -2, -3, -4, -5, -6);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL rst_pre_full: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || frame_zero_cnt !== 16'd0) begin
            n_bad++; $display("FAIL rst_async: got v=%b cnt=%0d want v=0 cnt=0", out_valid, frame_zero_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        spurious = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (frame_done !== 1'b0 || out_valid !== 1'b0) spurious = 1'b1;
        end
        n_cmp++; if (spurious !== 1'b0) begin n_bad++; $display("FAIL rst_no_done: got spurious=%b want 0", spurious); end
        send_single(pk(0, 5, 0, -2, 7, 8));
        @(posedge clk); @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== pk(0, 5, 0, 0, 7, 8)) begin
            n_bad++; $display("FAIL rst_next_out: got v=%b d=%h want v=1 d=%h", out_valid, out_data, pk(0, 5, 0, 0, 7, 8));
        end
        @(posedge clk); @(negedge clk);
        n_cmp++; if (frame_done !== 1'b1 || frame_zero_cnt !== 16'd3) begin
            n_bad++; $display("FAIL rst_next_count: got done=%b cnt=%0d want done=1 cnt=3", frame_done, frame_zero_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_relu();
        test_leaky();
        test_clip();
        test_backpressure();
        test_midframe_cfg();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
